axis_delay_scan_ctrl: RTL and testbench

Sequencer that sweeps the delay setting of an `axis_delay` instance. It finds the delay that maximises a per-beat "hit" qualifier on the delayed stream. For each candidate delay it drives the delay setting, waits for the shift register to flush, counts hits over a fixed number of accepted beats, and tracks the best setting. On completion it applies the best setting. The block sits in the IP clock domain beside `axis_delay`; software triggers scans through its own parameter registers.

---
 rtl/axis_delay_scan_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_axis_delay_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_delay_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axis_delay_scan_ctrl
// Brief    : Sweeps the delay setting of an axis_delay instance, counts hits
//            on the delayed stream over a fixed beat window per setting and
//            applies the setting that produced the most hits.
// Options  : AXIS_DELAY_SCAN_RESULT_EN - enables the per-step result
//            handshake (res_valid/res_ready/res_delay/res_count).
// Revision : 1.0 - initial release
// ============================================================================
module axis_delay_scan_ctrl #(
  parameter int DELAY_WIDTH   = 6,
  parameter int COUNT_WIDTH   = 32,
  parameter int SETTLE_CYCLES = 40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DELAY_WIDTH-1:0] delay_first,
  input  logic [DELAY_WIDTH-1:0] delay_last,
  input  logic [DELAY_WIDTH-1:0] delay_step,
  input  logic [COUNT_WIDTH-1:0] dwell_beats,
  input  logic                   mon_valid,
  input  logic                   mon_ready,
  input  logic                   mon_hit,
  output logic [DELAY_WIDTH-1:0] delay_out,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   cfg_error,
  output logic [DELAY_WIDTH-1:0] best_delay,
  output logic [COUNT_WIDTH-1:0] best_count,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DELAY_WIDTH-1:0] res_delay,
  output logic [COUNT_WIDTH-1:0] res_count
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SETTLE_W-1:0]    SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX   = '1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [DELAY_WIDTH-1:0] DELAY_ONE   = DELAY_WIDTH'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DWELL  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]             state_q,      state_d;
  logic [DELAY_WIDTH-1:0] cur_q,        cur_d;
  logic [DELAY_WIDTH-1:0] last_q,       last_d;
  logic [DELAY_WIDTH-1:0] step_q,       step_d;
  logic [COUNT_WIDTH-1:0] dwell_q,      dwell_d;
  logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [COUNT_WIDTH-1:0] beat_cnt_q,   beat_cnt_d;
  logic [COUNT_WIDTH-1:0] hit_cnt_q,    hit_cnt_d;
  logic                   first_q,      first_d;
  logic [DELAY_WIDTH-1:0] delay_out_q,  delay_out_d;
  logic                   busy_q,       busy_d;
  logic                   done_q,       done_d;
  logic                   aborted_q,    aborted_d;
  logic                   cfg_error_q,  cfg_error_d;
  logic [DELAY_WIDTH-1:0] best_delay_q, best_delay_d;
  logic [COUNT_WIDTH-1:0] best_count_q, best_count_d;
`ifdef AXIS_DELAY_SCAN_RESULT_EN
  logic                   res_valid_q,  res_valid_d;
  logic [DELAY_WIDTH-1:0] res_delay_q,  res_delay_d;
  logic [COUNT_WIDTH-1:0] res_count_q,  res_count_d;
`endif

  logic                   beat;
  logic                   hit;
  logic [COUNT_WIDTH-1:0] hit_next;
  logic [DELAY_WIDTH:0]   next_sum;
  logic                   next_past_end;

  // Per-beat qualifiers, saturating hit increment and next-delay evaluation
  always_comb begin
    beat          = mon_valid & mon_ready;
    hit           = beat & mon_hit;
    hit_next      = (hit && hit_cnt_q != COUNT_MAX) ? hit_cnt_q + COUNT_ONE : hit_cnt_q;
    // The extra MSB catches a sum that wraps the delay field.
    next_sum      = {1'b0, cur_q} + {1'b0, step_q};
    next_past_end = next_sum[DELAY_WIDTH] || (next_sum[DELAY_WIDTH-1:0] > last_q);
  end

  // Scan sequencer: next-state and next-output computation
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    step_d       = step_q;
    dwell_d      = dwell_q;
    settle_cnt_d = settle_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    first_d      = first_q;
    delay_out_d  = delay_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    cfg_error_d  = cfg_error_q;
    best_delay_d = best_delay_q;
    best_count_d = best_count_q;
`ifdef AXIS_DELAY_SCAN_RESULT_EN
    res_valid_d  = res_valid_q;
    res_delay_d  = res_delay_q;
    res_count_d  = res_count_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          cur_d        = delay_first;
          last_d       = delay_last;
          step_d       = (delay_step == '0) ? DELAY_ONE : delay_step;
          dwell_d      = (dwell_beats == '0) ? COUNT_ONE : dwell_beats;
          cfg_error_d  = 1'b0;
          best_delay_d = '0;
          best_count_d = '0;
          first_d      = 1'b1;
          settle_cnt_d = '0;
          beat_cnt_d   = '0;
          hit_cnt_d    = '0;
          if (delay_first > delay_last) begin
            // Bad range: report completion with the error flag, never go busy.
            cfg_error_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d = S_APPLY;
            busy_d  = 1'b1;
          end
        end
      end

      S_APPLY: begin
        delay_out_d  = cur_q;
        settle_cnt_d = '0;
        beat_cnt_d   = '0;
        hit_cnt_d    = '0;
        state_d      = S_SETTLE;
      end

      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = S_DWELL;
        end else begin
          settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end

      S_DWELL: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + COUNT_ONE;
          hit_cnt_d  = hit_next;
          if (beat_cnt_q + COUNT_ONE == dwell_q) begin
            state_d = S_REPORT;
            // Best tracking happens once, as the window closes; the first
            // step always seeds the best so a zero-hit sweep still names one.
            if (first_q || hit_next > best_count_q) begin
              best_delay_d = cur_q;
              best_count_d = hit_next;
            end
            first_d = 1'b0;
`ifdef AXIS_DELAY_SCAN_RESULT_EN
            res_valid_d = 1'b1;
            res_delay_d = cur_q;
            res_count_d = hit_next;
`endif
          end
        end
      end

      S_REPORT: begin
`ifdef AXIS_DELAY_SCAN_RESULT_EN
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          if (next_past_end) begin
            state_d = S_FINISH;
          end else begin
            cur_d   = next_sum[DELAY_WIDTH-1:0];
            state_d = S_APPLY;
          end
        end
`else
        if (next_past_end) begin
          state_d = S_FINISH;
        end else begin
          cur_d   = next_sum[DELAY_WIDTH-1:0];
          state_d = S_APPLY;
        end
`endif
      end

      S_FINISH: begin
        delay_out_d = best_delay_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides whatever the active state computed this cycle.
    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      aborted_d    = 1'b1;
      done_d       = 1'b0;
      busy_d       = 1'b0;
      delay_out_d  = delay_out_q;
      best_delay_d = best_delay_q;
      best_count_d = best_count_q;
`ifdef AXIS_DELAY_SCAN_RESULT_EN
      res_valid_d  = 1'b0;
      res_delay_d  = res_delay_q;
      res_count_d  = res_count_q;
`endif
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      step_q       <= '0;
      dwell_q      <= '0;
      settle_cnt_q <= '0;
      beat_cnt_q   <= '0;
      hit_cnt_q    <= '0;
      first_q      <= 1'b0;
      delay_out_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cfg_error_q  <= 1'b0;
      best_delay_q <= '0;
      best_count_q <= '0;
`ifdef AXIS_DELAY_SCAN_RESULT_EN
      res_valid_q  <= 1'b0;
      res_delay_q  <= '0;
      res_count_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      step_q       <= step_d;
      dwell_q      <= dwell_d;
      settle_cnt_q <= settle_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
      first_q      <= first_d;
      delay_out_q  <= delay_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      cfg_error_q  <= cfg_error_d;
      best_delay_q <= best_delay_d;
      best_count_q <= best_count_d;
`ifdef AXIS_DELAY_SCAN_RESULT_EN
      res_valid_q  <= res_valid_d;
      res_delay_q  <= res_delay_d;
      res_count_q  <= res_count_d;
`endif
    end
  end

  assign delay_out  = delay_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign cfg_error  = cfg_error_q;
  assign best_delay = best_delay_q;
  assign best_count = best_count_q;

`ifdef AXIS_DELAY_SCAN_RESULT_EN
  assign res_valid = res_valid_q;
  assign res_delay = res_delay_q;
  assign res_count = res_count_q;
`else
  // Result channel disabled: outputs held at zero, ready not consulted.
  logic unused_res_ready;
  assign unused_res_ready = res_ready;
  assign res_valid = 1'b0;
  assign res_delay = '0;
  assign res_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_delay_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_delay_scan_ctrl
// Brief    : Directed self-checking bench for axis_delay_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_delay_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [5:0]  delay_first = '0;
  logic [5:0]  delay_last = '0;
  logic [5:0]  delay_step = '0;
  logic [31:0] dwell_beats = '0;
  logic        mon_valid = 1'b1;
  logic        mon_ready = 1'b1;
  logic        mon_hit;
  logic [5:0]  delay_out;
  logic        busy, done, aborted, cfg_error;
  logic [5:0]  best_delay;
  logic [31:0] best_count;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [5:0]  res_delay;
  logic [31:0] res_count;

  int n_checks = 0;
  int n_fail   = 0;
  int hit_mode = 0;
  bit res_seen = 0;
  int n_res    = 0;
  logic [5:0]  res_d_log [8];
  logic [31:0] res_c_log [8];

  always #5 clk = ~clk;

  // Hit pattern 0: only delay 2 hits. Pattern 1: delays 1 and 3 hit.
  assign mon_hit = (hit_mode == 0) ? (delay_out == 6'd2)
                                   : (delay_out == 6'd1 || delay_out == 6'd3);

  axis_delay_scan_ctrl #(
    .DELAY_WIDTH(6), .COUNT_WIDTH(32), .SETTLE_CYCLES(40)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .delay_first(delay_first), .delay_last(delay_last),
    .delay_step(delay_step), .dwell_beats(dwell_beats),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_hit(mon_hit),
    .delay_out(delay_out), .busy(busy), .done(done), .aborted(aborted),
    .cfg_error(cfg_error), .best_delay(best_delay), .best_count(best_count),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_delay(res_delay), .res_count(res_count)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Issue one scan and watch it at falling edges until done plus a few cycles.
  task automatic run_scan(input logic [5:0] f, input logic [5:0] l, input logic [5:0] s,
                          input logic [31:0] dw, output int busy_cyc, output int done_cnt);
    int post;
    bit seen;
    @(negedge clk);
    delay_first = f; delay_last = l; delay_step = s; dwell_beats = dw;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cyc = 0; done_cnt = 0; post = 0; seen = 0;
    for (int g = 0; g < 3000; g++) begin
      if (busy) busy_cyc++;
      if (done) begin done_cnt++; seen = 1; end
      if (res_valid) res_seen = 1;
      if (res_valid && res_ready && n_res < 8) begin
        res_d_log[n_res] = res_delay;
        res_c_log[n_res] = res_count;
        n_res++;
      end
      if (seen) post++;
      if (post > 4) break;
      @(negedge clk);
    end
    if (!seen) check("scan_timeout", 0, 1);
  endtask

  initial begin
    int bc, dc, ab_cnt;
    bit stable;
    logic [5:0]  hold_d;
    logic [31:0] hold_c;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_delay_out", delay_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_cfg_error", cfg_error, 0);
    check("rst_best", {best_delay, best_count}, 0);
    check("rst_res", {res_valid, res_delay, res_count}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Sweep 0,2,4 with hits only at delay 2: three steps of 1+40+16+1 plus FINISH
    hit_mode = 0; n_res = 0; res_seen = 0;
    run_scan(6'd0, 6'd4, 6'd2, 32'd16, bc, dc);
    check("t1_busy_cycles", bc, 175);
    check("t1_done_pulses", dc, 1);
    check("t1_best_delay", best_delay, 2);
    check("t1_best_count", best_count, 16);
    check("t1_delay_out", delay_out, 2);
    check("t1_busy_after", busy, 0);
`ifdef AXIS_DELAY_SCAN_RESULT_EN
    check("t1_n_res", n_res, 3);
    check("t1_res0", {res_d_log[0], res_c_log[0]}, {6'd0, 32'd0});
    check("t1_res1", {res_d_log[1], res_c_log[1]}, {6'd2, 32'd16});
    check("t1_res2", {res_d_log[2], res_c_log[2]}, {6'd4, 32'd0});
`else
    check("t1_res_never_valid", res_seen, 0);
`endif

    // 60 + 5 overflows the 6-bit field: single step, no wrap to delay 1
    n_res = 0;
    run_scan(6'd60, 6'd63, 6'd5, 32'd4, bc, dc);
    check("t2_busy_cycles", bc, 47);
    check("t2_done_pulses", dc, 1);
    check("t2_best_delay", best_delay, 60);
    check("t2_best_count", best_count, 0);
    check("t2_delay_out", delay_out, 60);

    // Inverted range: error, immediate done, never busy, delay unchanged
    run_scan(6'd5, 6'd3, 6'd1, 32'd4, bc, dc);
    check("t3_busy_cycles", bc, 0);
    check("t3_done_pulses", dc, 1);
    check("t3_cfg_error", cfg_error, 1);
    check("t3_delay_out", delay_out, 60);

    // Tie at 8 hits on delays 1 and 3: first maximum wins
    hit_mode = 1; n_res = 0;
    run_scan(6'd1, 6'd3, 6'd2, 32'd8, bc, dc);
    check("t4_cfg_error_cleared", cfg_error, 0);
    check("t4_busy_cycles", bc, 101);
    check("t4_best_delay", best_delay, 1);
    check("t4_best_count", best_count, 8);
    check("t4_delay_out", delay_out, 1);

    // Abort during SETTLE of the second step (second APPLY at falling edge 59)
    hit_mode = 0; dc = 0; ab_cnt = 0;
    @(negedge clk);
    delay_first = 6'd0; delay_last = 6'd4; delay_step = 6'd2; dwell_beats = 32'd16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 70; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    check("t5_busy_before", busy, 1);
    check("t5_delay_before", delay_out, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_aborted", aborted, 1);
    check("t5_busy", busy, 0);
    check("t5_delay_out", delay_out, 2);
    check("t5_best", {best_delay, best_count}, {6'd0, 32'd0});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) dc++;
      if (aborted) ab_cnt++;
    end
    check("t5_no_done", dc, 0);
    check("t5_single_abort_pulse", ab_cnt, 0);

`ifdef AXIS_DELAY_SCAN_RESULT_EN
    // Stalled result: stable while ready low, hit count unaffected by traffic
    res_ready = 1'b0; hit_mode = 1;
    @(negedge clk);
    delay_first = 6'd1; delay_last = 6'd1; delay_step = 6'd1; dwell_beats = 32'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !res_valid; i++) @(negedge clk);
    check("t6_res_valid", res_valid, 1);
    hold_d = res_delay; hold_c = res_count; stable = 1;
    for (int i = 0; i < 50; i++) begin
      mon_valid = ~mon_valid;
      @(negedge clk);
      if (!res_valid || res_delay != hold_d || res_count != hold_c) stable = 0;
    end
    mon_valid = 1'b1;
    check("t6_stable", stable, 1);
    check("t6_res", {res_delay, res_count}, {6'd1, 32'd8});
    check("t6_best_count", best_count, 8);
    res_ready = 1'b1;
    @(negedge clk);
    check("t6_res_valid_fall", res_valid, 0);
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    check("t6_done", done, 1);
`endif

    // Reset in the middle of a scan clears everything
    hit_mode = 0;
    @(negedge clk);
    delay_first = 6'd1; delay_last = 6'd3; delay_step = 6'd1; dwell_beats = 32'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("t7_delay_mid", delay_out, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t7_busy", busy, 0);
    check("t7_delay_out", delay_out, 0);
    check("t7_best", {best_delay, best_count}, 0);
    repeat (60) @(negedge clk);
    check("t7_stays_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
